// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: decode/execute pipeline register with load-use hazard detection.
// Holds its contents while i_step is low. Inserts a bubble on flush or on a load-use hazard.
// Optional feature macro: ID_EX_LOAD_USE_STALL_EN. When it is defined, load-use hazard
// detection is active. When it is undefined, the hazard term is tied low and o_stall is
// constant 0, so software must place a NOP after each load.
module id_ex_stage_reg #(
    parameter int unsigned NB           = 32,
    parameter int unsigned NB_REGS      = 5,
    parameter int unsigned NB_SIZE_TYPE = 3,
    parameter int unsigned NB_FUNCT     = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic                    i_flush,
    input  logic                    i_ALUSrc,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_mem_to_reg,
    input  logic                    i_reg_write,
    input  logic                    i_branch,
    input  logic                    i_jump,
    input  logic                    i_signed,
    input  logic [1:0]              i_ExtensionMode,
    input  logic [NB_SIZE_TYPE-1:0] i_word_size,
    input  logic [NB_REGS-1:0]      i_reg_dir_to_write,
    input  logic [NB_REGS-1:0]      i_rs_addr,
    input  logic [NB_REGS-1:0]      i_rt_addr,
    input  logic [NB-1:0]           i_rs_data,
    input  logic [NB-1:0]           i_rt_data,
    input  logic [NB-1:0]           i_imm_ext,
    input  logic [NB-1:0]           i_pc4,
    input  logic [NB_FUNCT-1:0]     i_funct,
    output logic                    o_ALUSrc,
    output logic                    o_mem_read,
    output logic                    o_mem_write,
    output logic                    o_mem_to_reg,
    output logic                    o_reg_write,
    output logic                    o_branch,
    output logic                    o_jump,
    output logic                    o_signed,
    output logic [1:0]              o_ExtensionMode,
    output logic [NB_SIZE_TYPE-1:0] o_word_size,
    output logic [NB_REGS-1:0]      o_reg_dir_to_write,
    output logic [NB_REGS-1:0]      o_rs_addr,
    output logic [NB_REGS-1:0]      o_rt_addr,
    output logic [NB-1:0]           o_rs_data,
    output logic [NB-1:0]           o_rt_data,
    output logic [NB-1:0]           o_imm_ext,
    output logic [NB-1:0]           o_pc4,
    output logic [NB_FUNCT-1:0]     o_funct,
    output logic                    o_valid,
    output logic                    o_stall
);

    // Full EX-stage payload. An all-zero value is both the reset state and a bubble.
    typedef struct packed {
        logic                    alu_src;
        logic                    mem_read;
        logic                    mem_write;
        logic                    mem_to_reg;
        logic                    reg_write;
        logic                    branch;
        logic                    jump;
        logic                    is_signed;
        logic [1:0]              ext_mode;
        logic [NB_SIZE_TYPE-1:0] word_size;
        logic [NB_REGS-1:0]      rd;
        logic [NB_REGS-1:0]      rs_addr;
        logic [NB_REGS-1:0]      rt_addr;
        logic [NB-1:0]           rs_data;
        logic [NB-1:0]           rt_data;
        logic [NB-1:0]           imm_ext;
        logic [NB-1:0]           pc4;
        logic [NB_FUNCT-1:0]     funct;
        logic                    valid;
    } ex_stage_t;

    ex_stage_t stage_d;
    ex_stage_t stage_q;
    ex_stage_t load_c;
    logic      hazard_c;

    // Gather the decode-side inputs into the payload that a normal advance loads.
    always_comb begin
        load_c            = '0;
        load_c.alu_src    = i_ALUSrc;
        load_c.mem_read   = i_mem_read;
        load_c.mem_write  = i_mem_write;
        load_c.mem_to_reg = i_mem_to_reg;
        load_c.reg_write  = i_reg_write;
        load_c.branch     = i_branch;
        load_c.jump       = i_jump;
        load_c.is_signed  = i_signed;
        load_c.ext_mode   = i_ExtensionMode;
        load_c.word_size  = i_word_size;
        load_c.rd         = i_reg_dir_to_write;
        load_c.rs_addr    = i_rs_addr;
        load_c.rt_addr    = i_rt_addr;
        load_c.rs_data    = i_rs_data;
        load_c.rt_data    = i_rt_data;
        load_c.imm_ext    = i_imm_ext;
        load_c.pc4        = i_pc4;
        load_c.funct      = i_funct;
        load_c.valid      = 1'b1;
    end

`ifdef ID_EX_LOAD_USE_STALL_EN
    // A load in EX whose non-zero destination feeds either source of the decode instruction.
    always_comb begin
        hazard_c = stage_q.mem_read & stage_q.valid & (stage_q.rd != '0) &
                   ((stage_q.rd == i_rs_addr) | (stage_q.rd == i_rt_addr));
    end
`else
    // Hazard detection is compiled out, so software has to schedule around load-use cases.
    always_comb begin
        hazard_c = 1'b0;
    end
`endif

    // A stall is requested only when the pipe advances and the decode instruction is kept.
    always_comb begin
        o_stall = hazard_c & i_step & ~i_flush;
    end

    // Next-state selection: a low step holds; otherwise flush or hazard loads a bubble.
    always_comb begin
        stage_d = stage_q;
        if (i_step) begin
            if (i_flush || hazard_c) begin
                stage_d = '0;
            end else begin
                stage_d = load_c;
            end
        end
    end

    // Stage register, cleared asynchronously on reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Drive the registered outputs.
    always_comb begin
        o_ALUSrc           = stage_q.alu_src;
        o_mem_read         = stage_q.mem_read;
        o_mem_write        = stage_q.mem_write;
        o_mem_to_reg       = stage_q.mem_to_reg;
        o_reg_write        = stage_q.reg_write;
        o_branch           = stage_q.branch;
        o_jump             = stage_q.jump;
        o_signed           = stage_q.is_signed;
        o_ExtensionMode    = stage_q.ext_mode;
        o_word_size        = stage_q.word_size;
        o_reg_dir_to_write = stage_q.rd;
        o_rs_addr          = stage_q.rs_addr;
        o_rt_addr          = stage_q.rt_addr;
        o_rs_data          = stage_q.rs_data;
        o_rt_data          = stage_q.rt_data;
        o_imm_ext          = stage_q.imm_ext;
        o_pc4              = stage_q.pc4;
        o_funct            = stage_q.funct;
        o_valid            = stage_q.valid;
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vectors for id_ex_stage_reg.
// The expected stall behaviour follows ID_EX_LOAD_USE_STALL_EN in the same way the RTL does.
module tb_id_ex_stage_reg;

`ifdef ID_EX_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_step, i_flush;
    logic        i_ALUSrc, i_mem_read, i_mem_write, i_mem_to_reg;
    logic        i_reg_write, i_branch, i_jump, i_signed;
    logic [1:0]  i_ExtensionMode;
    logic [2:0]  i_word_size;
    logic [4:0]  i_reg_dir_to_write, i_rs_addr, i_rt_addr;
    logic [31:0] i_rs_data, i_rt_data, i_imm_ext, i_pc4;
    logic [5:0]  i_funct;
    logic        o_ALUSrc, o_mem_read, o_mem_write, o_mem_to_reg;
    logic        o_reg_write, o_branch, o_jump, o_signed;
    logic [1:0]  o_ExtensionMode;
    logic [2:0]  o_word_size;
    logic [4:0]  o_reg_dir_to_write, o_rs_addr, o_rt_addr;
    logic [31:0] o_rs_data, o_rt_data, o_imm_ext, o_pc4;
    logic [5:0]  o_funct;
    logic        o_valid, o_stall;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage_reg dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
        .i_ALUSrc(i_ALUSrc), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write), .i_branch(i_branch),
        .i_jump(i_jump), .i_signed(i_signed), .i_ExtensionMode(i_ExtensionMode),
        .i_word_size(i_word_size), .i_reg_dir_to_write(i_reg_dir_to_write),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm_ext(i_imm_ext), .i_pc4(i_pc4), .i_funct(i_funct),
        .o_ALUSrc(o_ALUSrc), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_branch(o_branch),
        .o_jump(o_jump), .o_signed(o_signed), .o_ExtensionMode(o_ExtensionMode),
        .o_word_size(o_word_size), .o_reg_dir_to_write(o_reg_dir_to_write),
        .o_rs_addr(o_rs_addr), .o_rt_addr(o_rt_addr), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm_ext(o_imm_ext), .o_pc4(o_pc4), .o_funct(o_funct),
        .o_valid(o_valid), .o_stall(o_stall)
    );

    always #5 i_clk = ~i_clk;

    // Count one comparison and report it when the observed value differs from the expected one.
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for one rising edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drive a NOP-like decode instruction with no source register and advancing enabled.
    task automatic idle_inputs();
        i_step = 1'b1; i_flush = 1'b0;
        i_ALUSrc = 0; i_mem_read = 0; i_mem_write = 0; i_mem_to_reg = 0;
        i_reg_write = 0; i_branch = 0; i_jump = 0; i_signed = 0;
        i_ExtensionMode = 2'd0; i_word_size = 3'd0; i_reg_dir_to_write = 5'd0;
        i_rs_addr = 5'd0; i_rt_addr = 5'd0; i_rs_data = '0; i_rt_data = '0;
        i_imm_ext = '0; i_pc4 = '0; i_funct = 6'd0;
    endtask

    // Drive a load word that writes rd, reading from base register 1.
    task automatic drive_lw(input logic [4:0] rd);
        idle_inputs();
        i_ALUSrc = 1; i_mem_read = 1; i_mem_to_reg = 1; i_reg_write = 1;
        i_word_size = 3'd2; i_reg_dir_to_write = rd; i_rs_addr = 5'd1;
        i_imm_ext = 32'h0000_0010; i_pc4 = 32'h0000_0104;
    endtask

    // Drive an R-type consumer that reads rs and rt and writes rd.
    task automatic drive_rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        idle_inputs();
        i_reg_write = 1; i_rs_addr = rs; i_rt_addr = rt; i_reg_dir_to_write = rd;
        i_rs_data = 32'h1111_0000; i_rt_data = 32'h0000_2222; i_funct = 6'h20;
        i_pc4 = 32'h0000_0108;
    endtask

    initial begin
        // Reset held low while random inputs are presented with the step enable high.
        i_reset = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            i_mem_read = 1'($urandom); i_reg_write = 1'($urandom);
            i_reg_dir_to_write = 5'($urandom); i_rs_addr = 5'($urandom);
            i_imm_ext = $urandom; i_pc4 = $urandom; i_funct = 6'($urandom);
            tick();
        end
        check_eq("rst_valid", 64'(o_valid), 64'd0);
        check_eq("rst_reg_write", 64'(o_reg_write), 64'd0);
        check_eq("rst_mem_read", 64'(o_mem_read), 64'd0);
        check_eq("rst_imm", 64'(o_imm_ext), 64'd0);
        check_eq("rst_pc4", 64'(o_pc4), 64'd0);
        check_eq("rst_stall", 64'(o_stall), 64'd0);

        // Release reset away from the clock edge, then step an ADDI through the stage.
        #2 i_reset = 1'b1;
        idle_inputs();
        i_ALUSrc = 1; i_reg_write = 1; i_reg_dir_to_write = 5'd5; i_rs_addr = 5'd2;
        i_imm_ext = 32'h0000_000A; i_pc4 = 32'h0000_0004;
        tick();
        check_eq("addi_reg_write", 64'(o_reg_write), 64'd1);
        check_eq("addi_rd", 64'(o_reg_dir_to_write), 64'd5);
        check_eq("addi_imm", 64'(o_imm_ext), 64'h0000_000A);
        check_eq("addi_valid", 64'(o_valid), 64'd1);
        check_eq("addi_alusrc", 64'(o_ALUSrc), 64'd1);

        // Load-use hazard: LW to r8 in EX, consumer reads r8 through rs.
        drive_lw(5'd8);
        tick();
        check_eq("lw8_mem_read", 64'(o_mem_read), 64'd1);
        drive_rtype(5'd8, 5'd9, 5'd10);
        #1;
        check_eq("lu_stall", 64'(o_stall), 64'(STALL_EN));
        tick();
        if (STALL_EN) begin
            check_eq("lu_bubble_valid", 64'(o_valid), 64'd0);
            check_eq("lu_bubble_reg_write", 64'(o_reg_write), 64'd0);
            check_eq("lu_bubble_rd", 64'(o_reg_dir_to_write), 64'd0);
            check_eq("lu_after_stall", 64'(o_stall), 64'd0);
            tick();
        end
        check_eq("lu_consumer_valid", 64'(o_valid), 64'd1);
        check_eq("lu_consumer_rd", 64'(o_reg_dir_to_write), 64'd10);
        check_eq("lu_consumer_funct", 64'(o_funct), 64'h20);
        check_eq("lu_consumer_rs_data", 64'(o_rs_data), 64'h1111_0000);

        // A load to register 0 never creates a hazard, even when rt is also 0.
        drive_lw(5'd0);
        tick();
        drive_rtype(5'd7, 5'd0, 5'd11);
        #1;
        check_eq("r0_stall", 64'(o_stall), 64'd0);
        tick();
        check_eq("r0_valid", 64'(o_valid), 64'd1);
        check_eq("r0_rd", 64'(o_reg_dir_to_write), 64'd11);

        // A flush takes priority over a pending hazard.
        drive_lw(5'd3);
        tick();
        drive_rtype(5'd3, 5'd4, 5'd12);
        i_flush = 1'b1;
        #1;
        check_eq("flush_stall", 64'(o_stall), 64'd0);
        tick();
        check_eq("flush_valid", 64'(o_valid), 64'd0);
        check_eq("flush_mem_read", 64'(o_mem_read), 64'd0);
        check_eq("flush_rd", 64'(o_reg_dir_to_write), 64'd0);

        // While the step enable is low, the stage holds its contents and suppresses the stall.
        drive_lw(5'd4);
        tick();
        drive_rtype(5'd4, 5'd6, 5'd13);
        i_step = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_rt_data = 32'hAB00_0000 + 32'(k);
            i_funct = 6'(k + 1);
            #1;
            check_eq("hold_stall", 64'(o_stall), 64'd0);
            tick();
            check_eq("hold_rd", 64'(o_reg_dir_to_write), 64'd4);
            check_eq("hold_mem_read", 64'(o_mem_read), 64'd1);
        end
        check_eq("hold_imm", 64'(o_imm_ext), 64'h0000_0010);
        i_step = 1'b1;
        #1;
        check_eq("resume_stall", 64'(o_stall), 64'(STALL_EN));
        tick();
        if (STALL_EN) begin
            check_eq("resume_bubble", 64'(o_valid), 64'd0);
            tick();
        end
        check_eq("resume_rd", 64'(o_reg_dir_to_write), 64'd13);
        check_eq("resume_rt_data", 64'(o_rt_data), 64'hAB00_0003);

        // Back-to-back loads to r8: each dependent consumer stalls once.
        drive_lw(5'd8);
        tick();
        drive_lw(5'd8);
        i_rs_addr = 5'd8;
        #1;
        check_eq("b2b_stall1", 64'(o_stall), 64'(STALL_EN));
        tick();
        if (STALL_EN) tick();
        check_eq("b2b_second_lw", 64'(o_mem_read & o_valid), 64'd1);
        drive_rtype(5'd2, 5'd8, 5'd14);
        #1;
        check_eq("b2b_stall2", 64'(o_stall), 64'(STALL_EN));

        // An asynchronous reset asserted mid-stall clears both the stage and the stall request.
        #2 i_reset = 1'b0;
        #1;
        check_eq("async_rst_valid", 64'(o_valid), 64'd0);
        check_eq("async_rst_mem_read", 64'(o_mem_read), 64'd0);
        check_eq("async_rst_stall", 64'(o_stall), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
